// File: rtl/gate_timing_pkg.sv
// Shared definitions for the gate timing pipe: operator encoding and legal parameter ranges.
package gate_timing_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned LAT_MIN   = 1;
    localparam int unsigned LAT_MAX   = 16;
    localparam int unsigned CNT_W_MIN = 1;
    localparam int unsigned CNT_W_MAX = 16;

endpackage

// File: rtl/gate_delay_line.sv
// Fixed-latency valid + data shift register of depth LAT; the last stage holds its
// data between valid pulses so it can drive a hold-last-value output directly.
module gate_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic [LAT-1:0]   r_vld;
    logic [WIDTH-1:0] r_data [LAT];

    // Valid bits shift every cycle; a data stage only loads behind a valid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            if (i_vld) begin
                r_data[0] <= i_data;
            end
            for (int unsigned k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    assign o_vld  = r_vld[LAT-1];
    assign o_data = r_data[LAT-1];

endmodule

// File: rtl/gate_timing_pipe.sv
// Bitwise gate with fixed result latency plus setup/hold violation monitor on the
// operand inputs (sticky flag and saturating count).
module gate_timing_pipe
    import gate_timing_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             in_valid,
    input  logic             en,
    input  logic             viol_clr,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             viol,
    output logic [CNT_W-1:0] viol_cnt
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || LAT < LAT_MIN || LAT > LAT_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cfg
        $error("gate_timing_pipe: parameter out of legal range");
    end

    op_e              w_op;
    logic             w_capture;
    logic             w_setup;
    logic             w_hold;
    logic             w_viol;
    logic [WIDTH-1:0] w_result;

    logic             r_cap_vld;
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic [WIDTH-1:0] r_cap_res;
    logic [WIDTH-1:0] r_prev_a;
    logic [WIDTH-1:0] r_prev_b;
    logic             r_prev_en;
    logic             r_arm;
    logic             r_viol;
    logic [CNT_W-1:0] r_cnt;

    assign w_op      = op_e'(op);
    assign w_capture = in_valid & en;

    // Bitwise function selected by the op sampled on the capture cycle
    always_comb begin
        w_result = '0;
        case (w_op)
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_NAND: w_result = ~(a & b);
            default: w_result = '0;
        endcase
    end

    // Setup: operands moved into a capture edge while en was high the edge before.
    // Hold: operands moved on the edge right after a capture.
    assign w_setup = w_capture & r_prev_en & ((a != r_prev_a) | (b != r_prev_b));
    assign w_hold  = r_cap_vld & ((a != r_cap_a) | (b != r_cap_b));
    assign w_viol  = r_arm & (w_setup | w_hold);

    // Capture stage: result plus the operand references used by the hold check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_vld <= 1'b0;
            r_cap_a   <= '0;
            r_cap_b   <= '0;
            r_cap_res <= '0;
        end else begin
            r_cap_vld <= w_capture;
            if (w_capture) begin
                r_cap_a   <= a;
                r_cap_b   <= b;
                r_cap_res <= w_result;
            end
        end
    end

    // Previous-edge operand/en samples for the setup check, and the post-reset arm flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_a  <= '0;
            r_prev_b  <= '0;
            r_prev_en <= 1'b0;
            r_arm     <= 1'b0;
        end else begin
            r_prev_a  <= a;
            r_prev_b  <= b;
            r_prev_en <= en;
            r_arm     <= 1'b1;
        end
    end

    // Sticky flag and saturating count; a clear discards any same-cycle violation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_viol <= 1'b0;
            r_cnt  <= '0;
        end else if (viol_clr) begin
            r_viol <= 1'b0;
            r_cnt  <= '0;
        end else if (w_viol) begin
            r_viol <= 1'b1;
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    gate_delay_line #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_cap_vld),
        .i_data (r_cap_res),
        .o_vld  (out_valid),
        .o_data (c)
    );

    assign viol     = r_viol;
    assign viol_cnt = r_cnt;

endmodule

// File: tb/tb_gate_timing_pipe.sv
// Self-checking bench for gate_timing_pipe: directed scenarios plus random traffic,
// checked against a history-based model of the latency and violation rules.
module tb_gate_timing_pipe;

    localparam int W    = 8;
    localparam int LAT  = 5;
    localparam int HN   = 2048;

    logic         clk;
    logic         rst;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         in_valid, en, viol_clr;

    logic [W-1:0] c1, c2;
    logic         ov1, ov2, viol1, viol2;
    logic [7:0]   cnt1;
    logic [1:0]   cnt2;

    gate_timing_pipe #(.WIDTH(W), .LAT(LAT), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid), .en(en),
        .viol_clr(viol_clr), .c(c1), .out_valid(ov1), .viol(viol1), .viol_cnt(cnt1)
    );

    gate_timing_pipe #(.WIDTH(W), .LAT(LAT), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .in_valid(in_valid), .en(en),
        .viol_clr(viol_clr), .c(c2), .out_valid(ov2), .viol(viol2), .viol_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state: per-edge history since reset release
    int           n;
    logic [W-1:0] ha [HN];
    logic [W-1:0] hb [HN];
    logic [W-1:0] hres [HN];
    bit           hen [HN];
    bit           hcap [HN];
    logic [W-1:0] exp_c;
    bit           exp_ov, exp_viol;
    int           exp_cnt, exp_cnt2;

    function automatic logic [W-1:0] ref_op(logic [1:0] f, logic [W-1:0] x, logic [W-1:0] y);
        case (f)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        exp_c = '0; exp_ov = 0; exp_viol = 0; exp_cnt = 0; exp_cnt2 = 0;
    endtask

    task automatic check_all();
        check("c",         64'(c1),   64'(exp_c));
        check("out_valid", 64'(ov1),  64'(exp_ov));
        check("viol",      64'(viol1), 64'(exp_viol));
        check("viol_cnt",  64'(cnt1), 64'(exp_cnt));
        check("c_w2",      64'(c2),   64'(exp_c));
        check("ov_w2",     64'(ov2),  64'(exp_ov));
        check("viol_w2",   64'(viol2), 64'(exp_viol));
        check("cnt_w2",    64'(cnt2), 64'(exp_cnt2));
    endtask

    // one clock edge: record the sampled inputs, derive expectations, then check
    task automatic step();
        bit cap, setup, hold, moved;
        @(posedge clk);
        cap     = in_valid && en;
        ha[n]   = a;
        hb[n]   = b;
        hen[n]  = en;
        hcap[n] = cap;
        hres[n] = ref_op(op, a, b);
        setup = 0;
        hold  = 0;
        if (n >= 1) begin
            moved = (a != ha[n-1]) || (b != hb[n-1]);
            setup = cap && hen[n-1] && moved;
            hold  = hcap[n-1] && moved;
        end
        exp_ov = 0;
        if (n >= LAT) begin
            exp_ov = hcap[n-LAT];
            if (exp_ov) exp_c = hres[n-LAT];
        end
        if (viol_clr) begin
            exp_viol = 0; exp_cnt = 0; exp_cnt2 = 0;
        end else if (setup || hold) begin
            exp_viol = 1;
            exp_cnt  = (exp_cnt  < 255) ? exp_cnt + 1  : 255;
            exp_cnt2 = (exp_cnt2 < 3)   ? exp_cnt2 + 1 : 3;
        end
        n++;
        #1;
        check_all();
    endtask

    int ov_seen;

    initial begin
        rst = 1'b1; a = '0; b = '0; op = 2'd0; in_valid = 0; en = 0; viol_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk) rst = 1'b0;

        // AND then XOR on the same operands
        a = 8'hF0; b = 8'h3C; op = 2'd0; in_valid = 1; en = 1;
        step();
        op = 2'd2;
        step();
        in_valid = 0;
        repeat (3) step();
        step();
        check("and_result", 64'(c1), 64'h30);
        check("and_valid",  64'(ov1), 64'h1);
        step();
        check("xor_result", 64'(c1), 64'hCC);
        step();
        check("xor_hold",   64'(c1), 64'hCC);

        // eight back-to-back OR captures
        ov_seen = 0;
        op = 2'd1; in_valid = 1; en = 1;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            step();
            if (ov1) ov_seen++;
        end
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ov1) ov_seen++;
        end
        check("b2b_pulses", 64'(ov_seen), 64'd8);

        // setup then hold violation
        a = 8'h00; b = 8'h00; en = 1; in_valid = 0; viol_clr = 1;
        step();
        step();
        viol_clr = 0;
        a = 8'h01; in_valid = 1;
        step();
        check("setup_viol", 64'(viol1), 64'h1);
        check("setup_cnt",  64'(cnt1),  64'd1);
        a = 8'h02;
        step();
        check("hold_cnt",   64'(cnt1),  64'd2);
        in_valid = 0;
        step();

        // saturation of the 2-bit counter, then clear beating a violation
        viol_clr = 1;
        step();
        viol_clr = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            a = a + 8'd1;
            step();
        end
        check("sat_cnt2", 64'(cnt2), 64'd3);
        check("cnt8_5",   64'(cnt1), 64'd5);
        a = a + 8'd1; viol_clr = 1;
        step();
        check("clr_cnt",  64'(cnt1),  64'd0);
        check("clr_viol", 64'(viol1), 64'd0);
        check("clr_cnt2", 64'(cnt2),  64'd0);
        viol_clr = 0; in_valid = 0;
        step();

        // random traffic with narrow operand range so equal values recur
        for (int i = 0; i < 300; i++) begin
            a        = 8'($urandom_range(0, 3));
            b        = 8'($urandom_range(0, 3));
            op       = 2'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            en       = ($urandom_range(0, 3) != 0);
            viol_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        viol_clr = 0;

        // reset with three captures in flight
        in_valid = 1; en = 1;
        for (int i = 0; i < 3; i++) begin
            a = 8'(8'h40 + i); b = 8'h0F;
            step();
        end
        #1;
        rst = 1'b1;
        #1;
        check("rst_c",    64'(c1),    64'd0);
        check("rst_ov",   64'(ov1),   64'd0);
        check("rst_viol", 64'(viol1), 64'd0);
        check("rst_cnt",  64'(cnt1),  64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        a = 8'hA5; b = 8'h5A; in_valid = 1; en = 1; op = 2'd3;
        step();
        check("first_edge_viol", 64'(viol1), 64'd0);
        in_valid = 0;
        ov_seen = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            if (ov1) ov_seen++;
        end
        check("post_rst_pulses", 64'(ov_seen), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
